// File: rtl/wi23_defs.sv
// Shared definitions for the WI23 I/O blocks used by the SPART.
//   spart_ioaddr_t   : SPART register select (DBUF, SREG, DBL, DBH)
//   SPART_DB_RESET   : baud divisor after reset (50 MHz / 115200 baud)
//   SPART_RXFIFO_AW  : log2 of the receive FIFO depth
//   SREG_OVR/FERR    : status register flag bit positions
//   spart_rx_state_t : receiver frame FSM states
package wi23_defs;

  typedef enum logic [1:0] {
    SPART_DBUF = 2'b00,
    SPART_SREG = 2'b01,
    SPART_DBL  = 2'b10,
    SPART_DBH  = 2'b11
  } spart_ioaddr_t;

  localparam logic [15:0] SPART_DB_RESET  = 16'd434;
  localparam int unsigned SPART_RXFIFO_AW = 3;

  localparam int unsigned SREG_OVR  = 7;
  localparam int unsigned SREG_FERR = 6;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } spart_rx_state_t;

endpackage

// File: rtl/spart_fifo.sv
// Synchronous byte FIFO, depth 2^AW.
//   push/wdata : enqueue; accepted when not full, or when full with a pop
//   pop/rdata  : dequeue; rdata shows the head, pop ignored when empty
//   full/empty/count : registered occupancy state
module spart_fifo #(
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == DEPTH_C);
    count   = count_q;
    rdata   = mem_q[rptr_q];
    pop_ok  = pop & ~empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push_ok = push & (~full | pop_ok);
    wptr_d  = push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop_ok  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    if (push_ok && !pop_ok) count_d = count_q + 1'b1;
    if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/spart_rx.sv
// SPART receive half: 8N1 deserializer, RX FIFO, status and baud divisor.
//   clk, rst_n      : system clock, async active-low reset
//   iocs/iorw/ioaddr: one-cycle register access (iorw 1 = read)
//   wdata/rdata     : write data / combinational read data
//   rx              : asynchronous serial input, idle high
//   rx_rdy          : receive FIFO non-empty
//   divisor         : {DBH,DBL}, shared with the transmit half
module spart_rx
  import wi23_defs::*;
#(
  parameter logic [15:0] DB_RESET = SPART_DB_RESET,
  parameter int unsigned FIFO_AW  = SPART_RXFIFO_AW
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        iocs,
  input  logic        iorw,
  input  logic [1:0]  ioaddr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  input  logic        rx,
  output logic        rx_rdy,
  output logic [15:0] divisor
);

  spart_ioaddr_t   addr;
  spart_rx_state_t state_q, state_d;

  logic         rx_meta_q, rx_s_q;
  logic [15:0]  div_q, div_d;
  logic [15:0]  dv;
  logic [15:0]  dvf_q, dvf_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [2:0]   bit_idx_q, bit_idx_d;
  logic [7:0]   shift_q, shift_d;
  logic         ovr_q, ovr_d;
  logic         ferr_q, ferr_d;
  logic         cnt_zero;
  logic         push, ferr_ev, ovr_ev;
  logic         rd, wr, pop, sreg_rd;

  logic [7:0]       fifo_rdata;
  logic             fifo_full, fifo_empty;
  logic [FIFO_AW:0] fifo_count;
  logic [3:0]       count4;

  always_comb begin
    addr     = spart_ioaddr_t'(ioaddr);
    rd       = iocs & iorw;
    wr       = iocs & ~iorw;
    pop      = rd & (addr == SPART_DBUF) & ~fifo_empty;
    sreg_rd  = rd & (addr == SPART_SREG);
    dv       = (div_q < 16'd2) ? 16'd2 : div_q;
    cnt_zero = (cnt_q == '0);
    divisor  = div_q;
    rx_rdy   = ~fifo_empty;
    count4   = 4'(fifo_count);
  end

  // Synchronizer: rx_s_q is the only copy of rx the FSM looks at.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RX_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RX_IDLE:  if (!rx_s_q) state_d = RX_START;
      RX_START: if (cnt_zero) state_d = rx_s_q ? RX_IDLE : RX_DATA;
      RX_DATA:  if (cnt_zero && bit_idx_q == 3'd7) state_d = RX_STOP;
      RX_STOP:  if (cnt_zero) state_d = RX_IDLE;
      default:  state_d = RX_IDLE;
    endcase
  end

  // The divisor is captured at start-bit detection, so a mid-frame divisor
  // write only reaches the reload of the next frame and the current one
  // keeps its bit timing.
  always_comb begin
    cnt_d     = cnt_zero ? cnt_q : cnt_q - 16'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    dvf_d     = dvf_q;
    push      = 1'b0;
    ferr_ev   = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        if (!rx_s_q) begin
          dvf_d = dv;
          cnt_d = (dv >> 1) - 16'd1;
        end
      end
      RX_START: begin
        if (cnt_zero && !rx_s_q) begin
          cnt_d     = dvf_q - 16'd1;
          bit_idx_d = '0;
        end
      end
      RX_DATA: begin
        if (cnt_zero) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          cnt_d     = dvf_q - 16'd1;
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (cnt_zero) begin
          push    = rx_s_q;
          ferr_ev = ~rx_s_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ovr_ev = push & fifo_full & ~pop;
    // A flag event in the same cycle as an SREG read keeps the flag set.
    ovr_d  = ovr_ev  | (ovr_q  & ~sreg_rd);
    ferr_d = ferr_ev | (ferr_q & ~sreg_rd);
    div_d  = div_q;
    if (wr && addr == SPART_DBL) div_d[7:0]  = wdata;
    if (wr && addr == SPART_DBH) div_d[15:8] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= DB_RESET;
      dvf_q     <= DB_RESET;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      div_q     <= div_d;
      dvf_q     <= dvf_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      unique case (addr)
        SPART_DBUF: rdata = fifo_empty ? 8'h00 : fifo_rdata;
        SPART_SREG: begin
          rdata            = {4'b0000, count4};
          rdata[SREG_OVR]  = ovr_q;
          rdata[SREG_FERR] = ferr_q;
        end
        SPART_DBL:  rdata = div_q[7:0];
        SPART_DBH:  rdata = div_q[15:8];
        default:    rdata = '0;
      endcase
    end
  end

  spart_fifo #(
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (shift_q),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule
